// File: rtl/wht_disto_pkg.sv
// Shared widths and helpers for the weighted-Hadamard distortion engine.
// Derived widths follow from the pixel and weight widths.
package wht_disto_pkg;

    localparam int DISTO_SHIFT = 5;
    localparam int PIX_W_D     = 8;
    localparam int W_W_D       = 16;
    localparam int SUM_W_D     = 32;
    localparam int CNT_W_D     = 5;

    typedef struct packed {
        logic vld;
        logic last;
    } ctl_t;

    function automatic int abs_w(input int pix_w);
        return pix_w + 4;
    endfunction

    function automatic int prod_w(input int pix_w, input int w_w);
        return abs_w(pix_w) + w_w;
    endfunction

    function automatic int sum_w(input int pix_w, input int w_w);
        return prod_w(pix_w, w_w) + 4;
    endfunction

endpackage

// File: rtl/wht4x4_abs.sv
// Registered 4x4 Walsh-Hadamard transform of one pixel block,
// emitting coefficient magnitudes (index 4*vertical + horizontal).
module wht4x4_abs
    import wht_disto_pkg::*;
#(
    parameter int PIX_W = PIX_W_D
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [16*PIX_W-1:0]               blk,
    output logic [15:0][abs_w(PIX_W)-1:0]     coef
);

    localparam int AW = abs_w(PIX_W);
    localparam int IW = AW + 1;

    // Modular IW-bit butterflies are exact: every true value fits signed IW.
    function automatic logic [3:0][IW-1:0] wht4(
        input logic [IW-1:0] p0,
        input logic [IW-1:0] p1,
        input logic [IW-1:0] p2,
        input logic [IW-1:0] p3
    );
        logic [IW-1:0] a0, a1, a2, a3;
        a0 = p0 + p2;
        a1 = p1 + p3;
        a2 = p1 - p3;
        a3 = p0 - p2;
        wht4[0] = a0 + a1;
        wht4[1] = a3 + a2;
        wht4[2] = a3 - a2;
        wht4[3] = a0 - a1;
    endfunction

    logic [15:0][IW-1:0] x, h, t, n;
    logic [15:0][AW-1:0] mag;

    for (genvar i = 0; i < 16; i++) begin : g_pix
        assign x[i]   = IW'(blk[PIX_W*i +: PIX_W]);
        assign n[i]   = '0 - t[i];
        assign mag[i] = t[i][IW-1] ? AW'(n[i]) : AW'(t[i]);
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign h[4*r +: 4] = wht4(x[4*r], x[4*r+1], x[4*r+2], x[4*r+3]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign {t[12+c], t[8+c], t[4+c], t[c]} =
            wht4(h[c], h[4+c], h[8+c], h[12+c]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef <= '0;
        end else if (en) begin
            coef <= mag;
        end
    end

endmodule

// File: rtl/wht_disto_acc.sv
// Streaming weighted-Hadamard distortion, accumulated per group.
// Define WHT_DISTO_SAT_EN for a saturating group accumulator.
module wht_disto_acc
    import wht_disto_pkg::*;
#(
    parameter int PIX_W = PIX_W_D,
    parameter int W_W   = W_W_D,
    parameter int SUM_W = SUM_W_D,
    parameter int CNT_W = CNT_W_D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [16*PIX_W-1:0] in_a,
    input  logic [16*PIX_W-1:0] in_b,
    input  logic [16*W_W-1:0]  in_w,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SUM_W-1:0]   out_disto,
    output logic [CNT_W-1:0]   out_cnt
);

    localparam int AW   = abs_w(PIX_W);
    localparam int S2_W = sum_w(PIX_W, W_W);
    localparam int DW   = S2_W + 1;
    localparam int XW   = ((DW > SUM_W) ? DW : SUM_W) + 1;

    function automatic logic signed [S2_W-1:0] mac_term(
        input logic [AW-1:0]  m,
        input logic [W_W-1:0] w
    );
        logic signed [S2_W-1:0] mv, wv;
        mv = {{(S2_W-AW){1'b0}}, m};
        wv = {{(S2_W-W_W){w[W_W-1]}}, w};
        return mv * wv;
    endfunction

    logic                   adv, rdy_q, open_q;
    ctl_t                   c1, c2;
    logic [15:0][AW-1:0]    abs_a, abs_b;
    logic [15:0][W_W-1:0]   w1;
    logic signed [S2_W-1:0] sa, sb, sa_c, sb_c;
    logic signed [DW-1:0]   diff;
    logic [DW-1:0]          mag, d;
    logic [XW-1:0]          d_x, base_x;
    logic [SUM_W-1:0]       acc, acc_new;
    logic [CNT_W-1:0]       cnt, cnt_new;

    assign adv      = !out_valid || out_ready;
    assign in_ready = rdy_q && adv;

    wht4x4_abs #(.PIX_W(PIX_W)) u_wht_a (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (adv),
        .blk  (in_a),
        .coef (abs_a)
    );

    wht4x4_abs #(.PIX_W(PIX_W)) u_wht_b (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (adv),
        .blk  (in_b),
        .coef (abs_b)
    );

    always_comb begin
        sa_c = '0;
        sb_c = '0;
        for (int i = 0; i < 16; i++) begin
            sa_c = sa_c + mac_term(abs_a[i], w1[i]);
            sb_c = sb_c + mac_term(abs_b[i], w1[i]);
        end
    end

    assign diff   = {sa[S2_W-1], sa} - {sb[S2_W-1], sb};
    assign mag    = diff[DW-1] ? -diff : diff;
    assign d      = mag >> DISTO_SHIFT;
    assign d_x    = {{(XW-DW){1'b0}}, d};
    // A closed group restarts from this block's distortion alone.
    assign base_x = open_q ? {{(XW-SUM_W){1'b0}}, acc} : '0;

`ifdef WHT_DISTO_SAT_EN
    localparam logic [XW-1:0] MAX_X = {{(XW-SUM_W){1'b0}}, {SUM_W{1'b1}}};
    logic [XW-1:0] dc_x, sum_x;
    always_comb begin
        dc_x    = (d_x > MAX_X) ? MAX_X : d_x;
        sum_x   = base_x + dc_x;
        acc_new = (sum_x > MAX_X) ? '1 : SUM_W'(sum_x);
    end
`else
    assign acc_new = SUM_W'(base_x + d_x);
`endif

    assign cnt_new = !open_q ? CNT_W'(1) :
                     (&cnt)  ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            c1        <= '0;
            c2        <= '0;
            w1        <= '0;
            sa        <= '0;
            sb        <= '0;
            open_q    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_disto <= '0;
            out_cnt   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (adv) begin
                c1        <= '{vld: in_valid && rdy_q, last: in_last};
                c2        <= c1;
                w1        <= in_w;
                sa        <= sa_c;
                sb        <= sb_c;
                out_valid <= c2.vld && c2.last;
                if (c2.vld) begin
                    acc    <= acc_new;
                    cnt    <= cnt_new;
                    open_q <= !c2.last;
                    if (c2.last) begin
                        out_disto <= acc_new;
                        out_cnt   <= cnt_new;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wht_disto_acc.sv
// Directed and table-driven bench for wht_disto_acc, with a 24-bit
// accumulator instance for the wrap/saturate boundary.
module tb_wht_disto_acc;

    typedef logic [15:0][7:0]  blk_t;
    typedef logic [15:0][15:0] wts_t;
    typedef struct {
        blk_t   a;
        blk_t   b;
        wts_t   w;
        longint d;
        longint c;
    } vec_t;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        in_valid = 0;
    logic        in_last = 0;
    logic        out_ready = 1;
    blk_t        in_a = '0;
    blk_t        in_b = '0;
    wts_t        in_w = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_disto;
    logic [4:0]  out_cnt;
    logic        in_ready24, out_valid24;
    logic [23:0] out_disto24;
    logic [4:0]  out_cnt24;

    wht_disto_acc dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_disto(out_disto), .out_cnt(out_cnt)
    );

    wht_disto_acc #(.SUM_W(24)) dut24 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready24),
        .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_last(in_last),
        .out_valid(out_valid24), .out_ready(out_ready),
        .out_disto(out_disto24), .out_cnt(out_cnt24)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tot = 0;
    int n_bad = 0;
    int last_acc = 0;
    longint got_d[$], got_c[$], got_t[$], got24[$];
    longint exp_d[$], exp_c[$], exp24[$];

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_d.push_back(longint'(out_disto));
            got_c.push_back(longint'(out_cnt));
            got_t.push_back(longint'(cyc));
            got24.push_back(longint'(out_disto24));
        end
    end

    // Hadamard matrix in the coefficient order used by the design.
    int hm[4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1},
                     '{1, -1, -1, 1}, '{1, -1, 1, -1}};

    longint m_acc32 = 0, m_acc24 = 0, m_cnt = 0;
    bit     m_open = 0;

    function automatic longint model_d(blk_t a, blk_t b, wts_t w);
        longint sa = 0, sb = 0, ca, cb, df;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) begin
                ca = 0;
                cb = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        ca += hm[k][r] * hm[i][c] * longint'(a[4*r+c]);
                        cb += hm[k][r] * hm[i][c] * longint'(b[4*r+c]);
                    end
                if (ca < 0) ca = -ca;
                if (cb < 0) cb = -cb;
                sa += ca * longint'($signed(w[4*k+i]));
                sb += cb * longint'($signed(w[4*k+i]));
            end
        df = sa - sb;
        if (df < 0) df = -df;
        return df >> 5;
    endfunction

    function automatic longint acc_step(longint acc, longint d, longint mx);
`ifdef WHT_DISTO_SAT_EN
        if (d > mx) d = mx;
        return (acc + d > mx) ? mx : acc + d;
`else
        return (acc + d) % (mx + 1);
`endif
    endfunction

    task automatic model_beat(blk_t a, blk_t b, wts_t w, bit last);
        longint d = model_d(a, b, w);
        if (!m_open) begin
            m_acc32 = 0;
            m_acc24 = 0;
            m_cnt   = 0;
        end
        m_acc32 = acc_step(m_acc32, d, 64'hFFFF_FFFF);
        m_acc24 = acc_step(m_acc24, d, 64'hFF_FFFF);
        m_cnt   = (m_cnt < 31) ? m_cnt + 1 : 31;
        m_open  = !last;
        if (last) begin
            exp_d.push_back(m_acc32);
            exp_c.push_back(m_cnt);
            exp24.push_back(m_acc24);
        end
    endtask

    task automatic chk(string nm, longint act, longint req);
        n_tot++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic beat(blk_t a, blk_t b, wts_t w, bit last);
        int g = 0;
        in_a = a;
        in_b = b;
        in_w = w;
        in_last = last;
        in_valid = 1;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            n_tot++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
            in_valid = 0;
            return;
        end
        @(negedge clk);
        in_valid = 0;
        in_last = 0;
        last_acc = cyc;
        model_beat(a, b, w, last);
    endtask

    task automatic clearq();
        got_d.delete(); got_c.delete(); got_t.delete(); got24.delete();
        exp_d.delete(); exp_c.delete(); exp24.delete();
    endtask

    task automatic check_q(string nm);
        chk({nm, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            chk({nm, "_disto"}, got_d[i], exp_d[i]);
            chk({nm, "_cnt"}, got_c[i], exp_c[i]);
            chk({nm, "_disto24"}, got24[i], exp24[i]);
        end
        clearq();
    endtask

    function automatic blk_t one_pix(int idx, logic [7:0] v);
        blk_t r = '0;
        r[idx] = v;
        return r;
    endfunction

    function automatic wts_t one_w(int idx, logic [15:0] v);
        wts_t r = '0;
        r[idx] = v;
        return r;
    endfunction

    function automatic vec_t mk(blk_t a, blk_t b, wts_t w, longint d, longint c);
        vec_t v;
        v.a = a; v.b = b; v.w = w; v.d = d; v.c = c;
        return v;
    endfunction

    vec_t tv[11];
    blk_t rnd_a, rnd_b, full, zero;
    wts_t rnd_w, w_dc, w_max;
    longint hold;
    int g;

`ifdef WHT_DISTO_SAT_EN
    localparam longint EXP5 = 16777215;
`else
    localparam longint EXP5 = 4111744;
`endif

    initial begin
        full = {16{8'hFF}};
        zero = '0;
        w_dc = one_w(0, 16'd1);
        w_max = {16{16'h7FFF}};
        for (int i = 0; i < 16; i++) rnd_a[i] = 8'($urandom_range(0, 255));
        tv[0]  = mk(rnd_a, rnd_a, {16{16'd1}}, 0, 1);
        tv[1]  = mk(full, zero, w_dc, 127, 1);
        tv[2]  = mk(zero, full, w_dc, 127, 1);
        tv[3]  = mk(full, zero, {16{16'd1}}, 127, 1);
        tv[4]  = mk({16{8'd100}}, zero, one_w(0, 16'hFFFF), 50, 1);
        tv[5]  = mk(one_pix(0, 8'd255), zero, {16{16'd1}}, 127, 1);
        tv[6]  = mk(one_pix(0, 8'd32), zero, {16{16'd2}}, 32, 1);
        tv[7]  = mk(one_pix(5, 8'd64), zero, one_w(15, 16'd3), 6, 1);
        tv[8]  = mk(one_pix(0, 8'd200), one_pix(0, 8'd100), w_dc, 3, 1);
        tv[9]  = mk(full, zero, {16{16'h8000}}, 4177920, 1);
        tv[10] = mk(one_pix(0, 8'd31), zero, w_dc, 0, 1);

        #2 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_disto", out_disto, 0);
        chk("rst_out_cnt", out_cnt, 0);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        for (int v = 0; v < 11; v++) begin
            clearq();
            beat(tv[v].a, tv[v].b, tv[v].w, 1);
            repeat (8) @(negedge clk);
            chk($sformatf("vec%0d_count", v), got_d.size(), 1);
            if (got_d.size() > 0) begin
                chk($sformatf("vec%0d_disto", v), got_d[0], tv[v].d);
                chk($sformatf("vec%0d_cnt", v), got_c[0], tv[v].c);
                if (v == 0) chk("latency", got_t[0] - last_acc, 2);
            end
        end
        clearq();

        for (int i = 0; i < 16; i++) beat(full, zero, w_dc, i == 15);
        repeat (8) @(negedge clk);
        chk("grp16_count", got_d.size(), 1);
        if (got_d.size() > 0) begin
            chk("grp16_disto", got_d[0], 2032);
            chk("grp16_cnt", got_c[0], 16);
        end
        clearq();

        for (int i = 0; i < 33; i++) beat(full, zero, w_dc, i == 32);
        repeat (8) @(negedge clk);
        chk("cntsat_count", got_d.size(), 1);
        if (got_d.size() > 0) begin
            chk("cntsat_disto", got_d[0], 4191);
            chk("cntsat_cnt", got_c[0], 31);
        end
        clearq();

        for (int i = 0; i < 4; i++) beat(full, zero, w_dc, 1);
        repeat (8) @(negedge clk);
        chk("b2b_count", got_d.size(), 4);
        for (int i = 0; i < got_d.size(); i++) begin
            chk("b2b_disto", got_d[i], 127);
            chk("b2b_cnt", got_c[i], 1);
        end
        clearq();

        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    for (int j = 0; j < 16; j++) begin
                        rnd_a[j] = 8'($urandom_range(0, 255));
                        rnd_b[j] = 8'($urandom_range(0, 255));
                        rnd_w[j] = 16'($urandom_range(0, 65535));
                    end
                    beat(rnd_a, rnd_b, rnd_w,
                         ($urandom_range(0, 2) == 0) || (i == 23));
                end
            end
            begin
                g = 0;
                do begin
                    @(posedge clk);
                    #1;
                    g++;
                end while (!out_valid && g < 300);
                chk("stall_seen_valid", out_valid, 1);
                out_ready = 0;
                hold = longint'(out_disto);
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_hold", out_disto, hold);
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        repeat (10) @(negedge clk);
        check_q("rand");

        for (int i = 0; i < 7; i++) beat(full, zero, w_dc, 0);
        rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_disto", out_disto, 0);
        chk("midrst_out_cnt", out_cnt, 0);
        chk("midrst_in_ready", in_ready, 0);
        m_open = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        clearq();
        beat(full, zero, w_dc, 0);
        beat(full, zero, w_dc, 1);
        repeat (8) @(negedge clk);
        chk("after_rst_count", got_d.size(), 1);
        if (got_d.size() > 0) begin
            chk("after_rst_disto", got_d[0], 254);
            chk("after_rst_cnt", got_c[0], 2);
        end
        clearq();

        for (int i = 0; i < 3; i++) beat(full, zero, w_max, i == 2);
        repeat (8) @(negedge clk);
        chk("w24_3_count", got24.size(), 1);
        if (got24.size() > 0) chk("w24_3_disto", got24[0], 12533376);
        check_q("w3");

        for (int i = 0; i < 5; i++) beat(full, zero, w_max, i == 4);
        repeat (8) @(negedge clk);
        chk("w24_5_count", got24.size(), 1);
        if (got24.size() > 0) chk("w24_5_disto", got24[0], EXP5);
        check_q("w5");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
